ex_operand_stage: RTL and testbench

//  ID/EX pipeline register and operand-forwarding stage sitting directly upstream of the ALU.

---
 rtl/ex_operand_stage_pkg.sv | 24 ++
 rtl/ex_operand_stage_fwd_mux.sv | 49 ++++
 rtl/ex_operand_stage.sv | 169 ++++++++++++++++
 tb/tb_ex_operand_stage.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Shared constants for the ID/EX operand stage.
//   ALU_*      : 4-bit ALU opcodes carried on alu_op
//   SEL_A_*    : operand_a source select (rs1 or pc)
//   SEL_B_*    : operand_b source select (rs2 or imm)
package ex_operand_stage_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLT  = 4'h5;
  localparam logic [3:0] ALU_SLTU = 4'h6;
  localparam logic [3:0] ALU_SLL  = 4'h7;
  localparam logic [3:0] ALU_SRL  = 4'h8;
  localparam logic [3:0] ALU_SRA  = 4'h9;
  localparam logic [3:0] ALU_LUI  = 4'hA;

  localparam logic SEL_A_RS1 = 1'b0;
  localparam logic SEL_A_PC  = 1'b1;
  localparam logic SEL_B_RS2 = 1'b0;
  localparam logic SEL_B_IMM = 1'b1;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source forwarding mux.
//   en             : entry is live; when low the held data passes through untouched
//   used           : the source actually feeds an ALU operand (select is rs, not pc/imm)
//   rs             : source register index
//   held_data      : value latched in the pipeline register
//   mem_*          : EX/MEM result bus; mem_data_valid low while a load is outstanding
//   wb_*           : writeback bus
//   data           : forwarded value (MEM beats WB beats held)
//   stall          : MEM producer matches but its data is not final yet
module ex_operand_stage_fwd_mux #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  en,
  input  logic                  used,
  input  logic [REG_AW-1:0]     rs,
  input  logic [DATA_WIDTH-1:0] held_data,
  input  logic [REG_AW-1:0]     mem_rd,
  input  logic                  mem_rd_we,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_data_valid,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic                  wb_rd_we,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  stall
);

  logic rs_nz;
  logic mem_hit;
  logic wb_hit;

  // x0 is hardwired to zero and is never a forwarding target.
  assign rs_nz   = |rs;
  assign mem_hit = en & rs_nz & mem_rd_we & (mem_rd == rs);
  assign wb_hit  = en & rs_nz & wb_rd_we & (wb_rd == rs);

  always_comb begin
    data = held_data;
    if (mem_hit) begin
      data = mem_data;
    end else if (wb_hit) begin
      data = wb_data;
    end
  end

  assign stall = used & mem_hit & ~mem_data_valid;

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding, feeding the ALU.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : kill the held entry and anything accepted this cycle
//   in_valid/in_ready   : handshake from decode
//   in_*                : decoded instruction fields and regfile reads
//   mem_*, wb_*         : result buses used for forwarding
//   out_valid/out_ready : handshake to EX/MEM
//   alu_op, operand_a/b : ALU inputs
//   out_rs2_data        : forwarded rs2 (store data / branch compare)
//   out_pc/rd/rd_we     : passed through; out_rd_we gated by out_valid
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int REG_AW     = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_alu_op,
  input  logic [REG_AW-1:0]     in_rs1,
  input  logic [REG_AW-1:0]     in_rs2,
  input  logic [DATA_WIDTH-1:0] in_rs1_data,
  input  logic [DATA_WIDTH-1:0] in_rs2_data,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic                  in_sel_a,
  input  logic                  in_sel_b,
  input  logic [REG_AW-1:0]     in_rd,
  input  logic                  in_rd_we,
  input  logic [REG_AW-1:0]     mem_rd,
  input  logic                  mem_rd_we,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_data_valid,
  input  logic [REG_AW-1:0]     wb_rd,
  input  logic                  wb_rd_we,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] operand_a,
  output logic [DATA_WIDTH-1:0] operand_b,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [DATA_WIDTH-1:0] out_pc,
  output logic [REG_AW-1:0]     out_rd,
  output logic                  out_rd_we
);

  logic                  v_q;
  logic [3:0]            alu_op_q;
  logic [REG_AW-1:0]     rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs2_data_q, imm_q, pc_q;
  logic                  sel_a_q, sel_b_q, rd_we_q;

  logic                  accept, advance, hazard;
  logic                  stall_rs1, stall_rs2;
  logic [DATA_WIDTH-1:0] fwd_rs1, fwd_rs2;
  logic [DATA_WIDTH-1:0] cap_rs1_data, cap_rs2_data;
  logic                  upd_rs1, upd_rs2;

  ex_operand_stage_fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_AW    (REG_AW)
  ) u_fwd_rs1 (
    .en            (v_q),
    .used          (sel_a_q == SEL_A_RS1),
    .rs            (rs1_q),
    .held_data     (rs1_data_q),
    .mem_rd        (mem_rd),
    .mem_rd_we     (mem_rd_we),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .wb_rd         (wb_rd),
    .wb_rd_we      (wb_rd_we),
    .wb_data       (wb_data),
    .data          (fwd_rs1),
    .stall         (stall_rs1)
  );

  ex_operand_stage_fwd_mux #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_AW    (REG_AW)
  ) u_fwd_rs2 (
    .en            (v_q),
    .used          (sel_b_q == SEL_B_RS2),
    .rs            (rs2_q),
    .held_data     (rs2_data_q),
    .mem_rd        (mem_rd),
    .mem_rd_we     (mem_rd_we),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .wb_rd         (wb_rd),
    .wb_rd_we      (wb_rd_we),
    .wb_data       (wb_data),
    .data          (fwd_rs2),
    .stall         (stall_rs2)
  );

  assign hazard    = stall_rs1 | stall_rs2;
  assign out_valid = v_q & ~hazard;
  assign advance   = out_valid & out_ready;
  assign in_ready  = ~v_q | advance;
  assign accept    = in_valid & in_ready & ~flush;

  // WB writing this cycle has not reached the regfile read that decode performed.
  assign cap_rs1_data = (wb_rd_we && (wb_rd == in_rs1) && (|in_rs1)) ? wb_data : in_rs1_data;
  assign cap_rs2_data = (wb_rd_we && (wb_rd == in_rs2) && (|in_rs2)) ? wb_data : in_rs2_data;

  // A held entry would otherwise lose a WB result once it retires from the bus.
  assign upd_rs1 = wb_rd_we & (wb_rd == rs1_q) & (|rs1_q);
  assign upd_rs2 = wb_rd_we & (wb_rd == rs2_q) & (|rs2_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q        <= 1'b0;
      alu_op_q   <= ALU_ADD;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      sel_a_q    <= 1'b0;
      sel_b_q    <= 1'b0;
      rd_we_q    <= 1'b0;
    end else begin
      if (flush) begin
        v_q <= 1'b0;
      end else if (accept) begin
        v_q <= 1'b1;
      end else if (advance) begin
        v_q <= 1'b0;
      end

      if (accept) begin
        alu_op_q   <= in_alu_op;
        rs1_q      <= in_rs1;
        rs2_q      <= in_rs2;
        rd_q       <= in_rd;
        rs1_data_q <= cap_rs1_data;
        rs2_data_q <= cap_rs2_data;
        imm_q      <= in_imm;
        pc_q       <= in_pc;
        sel_a_q    <= in_sel_a;
        sel_b_q    <= in_sel_b;
        rd_we_q    <= in_rd_we;
      end else if (v_q && (advance || flush)) begin
        // Entry leaves: freeze the forwarded values so idle outputs keep their last values.
        rs1_data_q <= fwd_rs1;
        rs2_data_q <= fwd_rs2;
      end else if (v_q) begin
        if (upd_rs1) rs1_data_q <= wb_data;
        if (upd_rs2) rs2_data_q <= wb_data;
      end
    end
  end

  assign alu_op       = alu_op_q;
  assign operand_a    = (sel_a_q == SEL_A_PC) ? pc_q : fwd_rs1;
  assign operand_b    = (sel_b_q == SEL_B_IMM) ? imm_q : fwd_rs2;
  assign out_rs2_data = fwd_rs2;
  assign out_pc       = pc_q;
  assign out_rd       = rd_q;
  assign out_rd_we    = rd_we_q & out_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;
  import ex_operand_stage_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk, rst, flush;
  logic          in_valid, in_ready;
  logic [3:0]    in_alu_op;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [DW-1:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic          in_sel_a, in_sel_b, in_rd_we;
  logic [AW-1:0] mem_rd, wb_rd;
  logic          mem_rd_we, mem_data_valid, wb_rd_we;
  logic [DW-1:0] mem_data, wb_data;
  logic          out_valid, out_ready;
  logic [3:0]    alu_op;
  logic [DW-1:0] operand_a, operand_b, out_rs2_data, out_pc;
  logic [AW-1:0] out_rd;
  logic          out_rd_we;

  int tests  = 0;
  int failed = 0;

  ex_operand_stage #(.DATA_WIDTH(DW), .REG_AW(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_op     (in_alu_op),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_pc         (in_pc),
    .in_sel_a      (in_sel_a),
    .in_sel_b      (in_sel_b),
    .in_rd         (in_rd),
    .in_rd_we      (in_rd_we),
    .mem_rd        (mem_rd),
    .mem_rd_we     (mem_rd_we),
    .mem_data      (mem_data),
    .mem_data_valid(mem_data_valid),
    .wb_rd         (wb_rd),
    .wb_rd_we      (wb_rd_we),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_op        (alu_op),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .out_rs2_data  (out_rs2_data),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_rd_we     (out_rd_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction fields, WB bus during capture, MEM/WB buses during the check cycle, expectations.
  typedef struct {
    logic [3:0]    op;
    logic [AW-1:0] rs1, rs2;
    logic [DW-1:0] d1, d2, imm, pc;
    logic          sa, sb;
    logic [AW-1:0] rd;
    logic          rdwe;
    logic          cwe;
    logic [AW-1:0] crd;
    logic [DW-1:0] cd;
    logic          mwe;
    logic [AW-1:0] mrd;
    logic [DW-1:0] md;
    logic          mdv;
    logic          wwe;
    logic [AW-1:0] wrd;
    logic [DW-1:0] wd;
    logic          ev;
    logic [DW-1:0] ea, eb, es2;
  } vec_t;

  vec_t vecs[9];
  vec_t s;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid       = 1'b0;
    flush          = 1'b0;
    out_ready      = 1'b1;
    mem_rd_we      = 1'b0;
    mem_rd         = '0;
    mem_data       = '0;
    mem_data_valid = 1'b1;
    wb_rd_we       = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
  endtask

  task automatic put(input vec_t v);
    in_valid    = 1'b1;
    in_alu_op   = v.op;
    in_rs1      = v.rs1;
    in_rs2      = v.rs2;
    in_rs1_data = v.d1;
    in_rs2_data = v.d2;
    in_imm      = v.imm;
    in_pc       = v.pc;
    in_sel_a    = v.sa;
    in_sel_b    = v.sb;
    in_rd       = v.rd;
    in_rd_we    = v.rdwe;
  endtask

  initial begin
    vecs[0] = '{ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, 5'd3, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0,
                1'b1, 32'd5, 32'd7, 32'd7};
    vecs[1] = '{ALU_SUB, 5'd4, 5'd5, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h11, 1'b1, 1'b1, 5'd4, 32'h22,
                1'b1, 32'h11, 32'd3, 32'd3};
    vecs[2] = '{ALU_SUB, 5'd4, 5'd5, 32'd1, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 5'd8, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b0, 5'd4, 32'h11, 1'b1, 1'b1, 5'd4, 32'h22,
                1'b1, 32'h22, 32'd3, 32'd3};
    vecs[3] = '{ALU_XOR, 5'd0, 5'd2, 32'd0, 32'd4, 32'd0, 32'd0, 1'b0, 1'b0, 5'd9, 1'b0,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 1'b1, 1'b1, 5'd0, 32'hEE,
                1'b1, 32'd0, 32'd4, 32'd4};
    vecs[4] = '{ALU_ADD, 5'd4, 5'd2, 32'd1, 32'd9, 32'd0, 32'h100, 1'b1, 1'b0, 5'd1, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44, 1'b0, 1'b0, 5'd0, 32'd0,
                1'b1, 32'h100, 32'd9, 32'd9};
    vecs[5] = '{ALU_ADD, 5'd1, 5'd6, 32'd2, 32'h66, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b1, 5'd2,
                1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 5'd6, 32'h77,
                1'b1, 32'd2, 32'hFFFF_FFF0, 32'h77};
    vecs[6] = '{ALU_OR, 5'd7, 5'd2, 32'hAA, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd10, 1'b1,
                1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0,
                1'b1, 32'hBB, 32'd1, 32'd1};
    vecs[7] = '{ALU_AND, 5'd0, 5'd2, 32'd5, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd11, 1'b1,
                1'b1, 5'd0, 32'hCC, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0,
                1'b1, 32'd5, 32'd1, 32'd1};
    vecs[8] = '{ALU_SLT, 5'd1, 5'd5, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 5'd12, 1'b1,
                1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h55, 1'b0, 1'b0, 5'd0, 32'd0,
                1'b0, 32'd1, 32'h55, 32'h55};

    rst = 1'b1;
    set_idle();
    put(vecs[0]);
    in_valid = 1'b0;
    #2;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.operand_a", operand_a, 32'd0);
    chk("reset.alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    chk("reset.out_rd_we", {31'd0, out_rd_we}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: one instruction per entry, accepted then checked the following cycle.
    for (int i = 0; i < 9; i++) begin
      set_idle();
      put(vecs[i]);
      wb_rd_we = vecs[i].cwe;
      wb_rd    = vecs[i].crd;
      wb_data  = vecs[i].cd;
      tick();
      in_valid       = 1'b0;
      mem_rd_we      = vecs[i].mwe;
      mem_rd         = vecs[i].mrd;
      mem_data       = vecs[i].md;
      mem_data_valid = vecs[i].mdv;
      wb_rd_we       = vecs[i].wwe;
      wb_rd          = vecs[i].wrd;
      wb_data        = vecs[i].wd;
      #1;
      chk($sformatf("v%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d.operand_a", i), operand_a, vecs[i].ea);
      chk($sformatf("v%0d.operand_b", i), operand_b, vecs[i].eb);
      chk($sformatf("v%0d.rs2_data", i), out_rs2_data, vecs[i].es2);
      chk($sformatf("v%0d.alu_op", i), {28'd0, alu_op}, {28'd0, vecs[i].op});
      chk($sformatf("v%0d.out_rd_we", i), {31'd0, out_rd_we},
          {31'd0, vecs[i].rdwe & vecs[i].ev});
      set_idle();
      tick();
    end

    // Load-use: MEM producer not final for two cycles.
    set_idle();
    s = vecs[0];
    s.rs1 = 5'd4;
    s.d1  = 32'd1;
    put(s);
    mem_rd_we = 1'b1; mem_rd = 5'd4; mem_data = 32'h44; mem_data_valid = 1'b0;
    tick();
    in_valid = 1'b0;
    #1;
    chk("lu.c1.out_valid", {31'd0, out_valid}, 32'd0);
    chk("lu.c1.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    #1;
    chk("lu.c2.out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    mem_data_valid = 1'b1;
    #1;
    chk("lu.c3.out_valid", {31'd0, out_valid}, 32'd1);
    chk("lu.c3.operand_a", operand_a, 32'h44);
    set_idle();
    tick();

    // Held entry picks up a WB write that later leaves the bus.
    set_idle();
    out_ready = 1'b0;
    s = vecs[0];
    s.rs2 = 5'd6;
    s.d2  = 32'h10;
    put(s);
    tick();
    in_valid = 1'b0;
    #1;
    chk("hwb.c1.operand_b", operand_b, 32'h10);
    tick();
    wb_rd_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h99;
    tick();
    wb_rd_we = 1'b0; wb_data = 32'h0;
    #1;
    chk("hwb.c3.operand_b", operand_b, 32'h99);
    chk("hwb.c3.out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    #1;
    chk("hwb.c4.operand_b", operand_b, 32'h99);
    out_ready = 1'b1;
    tick();

    // Back-to-back throughput.
    set_idle();
    s = vecs[0];
    s.op = ALU_AND;
    s.d1 = 32'hA1;
    put(s);
    tick();
    #1;
    chk("b2b.a.operand_a", operand_a, 32'hA1);
    chk("b2b.a.in_ready", {31'd0, in_ready}, 32'd1);
    s.op = ALU_OR;
    s.d1 = 32'hB2;
    put(s);
    tick();
    in_valid = 1'b0;
    #1;
    chk("b2b.b.operand_a", operand_a, 32'hB2);
    chk("b2b.b.alu_op", {28'd0, alu_op}, {28'd0, ALU_OR});
    chk("b2b.b.out_valid", {31'd0, out_valid}, 32'd1);
    tick();
    #1;
    chk("b2b.drain.out_valid", {31'd0, out_valid}, 32'd0);

    // Flush a held entry while decode presents a new one.
    set_idle();
    out_ready = 1'b0;
    s = vecs[0];
    s.d1 = 32'h31;
    put(s);
    tick();
    s.d1 = 32'h77;
    put(s);
    flush = 1'b1;
    #1;
    chk("flush.in_ready_held", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush.out_rd_we", {31'd0, out_rd_we}, 32'd0);
    chk("flush.operand_a_kept", operand_a, 32'h31);
    tick();
    #1;
    chk("flush.dropped", {31'd0, out_valid}, 32'd0);
    flush = 1'b1;
    #1;
    chk("flush.in_ready_empty", {31'd0, in_ready}, 32'd1);
    flush = 1'b0;
    out_ready = 1'b1;

    // Asynchronous reset while an entry is held.
    set_idle();
    out_ready = 1'b0;
    s = vecs[0];
    s.op = ALU_SUB;
    s.d1 = 32'd5;
    put(s);
    tick();
    in_valid = 1'b0;
    #1;
    chk("rstmid.before", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid.operand_a", operand_a, 32'd0);
    chk("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmid.alu_op", {28'd0, alu_op}, {28'd0, ALU_ADD});
    @(negedge clk);
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
